// File: rtl/bit_serial_logic_unit_pkg.sv
// Shared types for the bit-serial logic unit: opcode and FSM state encodings.
// Optional Z/P result flags are built when LOGIC_FLAGS_EN is defined.
package logic_unit_pkg;

    typedef enum logic [1:0] {
        OP_AND = 2'b00,
        OP_OR  = 2'b01,
        OP_XOR = 2'b10,
        OP_NOR = 2'b11
    } logic_op_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_SHIFT  = 2'b01,
        ST_FINISH = 2'b10
    } serial_state_t;

endpackage

// File: rtl/bit_serial_logic_unit_if.sv
// Request/result bundle of the bit-serial logic unit.
// Z and P exist only when LOGIC_FLAGS_EN is defined.
interface bit_serial_logic_unit_if
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = 8
);
    logic             START;
    logic_op_t        OP;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             READY;
    logic             BUSY;
    logic             DONE;
    logic [WIDTH-1:0] S;
`ifdef LOGIC_FLAGS_EN
    logic             Z;
    logic             P;
`endif

    modport master (
        output START, OP, A, B,
        input  READY, BUSY, DONE, S
`ifdef LOGIC_FLAGS_EN
        , input Z, P
`endif
    );

    modport slave (
        input  START, OP, A, B,
        output READY, BUSY, DONE, S
`ifdef LOGIC_FLAGS_EN
        , output Z, P
`endif
    );
endinterface

// File: rtl/bit_serial_logic_unit_cell.sv
// Single-bit combinational logic cell shared by every serial step.
// Opcode decoding matches the parallel gate slices.
module bit_logic_cell
    import logic_unit_pkg::*;
(
    input  logic      a_i,
    input  logic      b_i,
    input  logic_op_t op_i,
    output logic      r_o
);
    always_comb begin
        r_o = 1'b0;
        unique case (op_i)
            OP_AND:  r_o = a_i & b_i;
            OP_OR:   r_o = a_i | b_i;
            OP_XOR:  r_o = a_i ^ b_i;
            OP_NOR:  r_o = ~(a_i | b_i);
            default: r_o = 1'b0;
        endcase
    end
endmodule

// File: rtl/bit_serial_logic_unit.sv
// Bit-serial AND/OR/XOR/NOR unit: one bit per clock, LSB first, DONE pulse.
// Define LOGIC_FLAGS_EN to add registered zero (Z) and parity (P) flags.
module bit_serial_logic_unit
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input logic                    CLK,
    input logic                    RESET,
    bit_serial_logic_unit_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    serial_state_t    state_q;
    logic_op_t        op_q;
    logic [WIDTH-1:0] a_sr_q;
    logic [WIDTH-1:0] b_sr_q;
    logic [WIDTH-1:0] res_q;
    logic [WIDTH-1:0] res_d;
    logic [WIDTH-1:0] s_q;
    logic [CW-1:0]    cnt_q;
    logic             ready_q;
    logic             busy_q;
    logic             done_q;
    logic             r;
`ifdef LOGIC_FLAGS_EN
    logic             z_q;
    logic             p_q;
`endif

    bit_logic_cell u_cell (
        .a_i  (a_sr_q[0]),
        .b_i  (b_sr_q[0]),
        .op_i (op_q),
        .r_o  (r)
    );

    // New bit enters at the MSB so the word is aligned after WIDTH steps.
    assign res_d = {r, res_q[WIDTH-1:1]};

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= ST_IDLE;
            op_q    <= OP_AND;
            a_sr_q  <= '0;
            b_sr_q  <= '0;
            res_q   <= '0;
            s_q     <= '0;
            cnt_q   <= '0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef LOGIC_FLAGS_EN
            z_q     <= 1'b1;
            p_q     <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (bus.START) begin
                        a_sr_q  <= bus.A;
                        b_sr_q  <= bus.B;
                        op_q    <= bus.OP;
                        res_q   <= '0;
                        cnt_q   <= '0;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    a_sr_q <= a_sr_q >> 1;
                    b_sr_q <= b_sr_q >> 1;
                    res_q  <= res_d;
                    if (cnt_q == CNT_LAST) begin
                        s_q     <= res_d;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_FINISH;
`ifdef LOGIC_FLAGS_EN
                        z_q     <= (res_d == '0);
                        p_q     <= ^res_d;
`endif
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                ST_FINISH: begin
                    ready_q <= 1'b1;
                    state_q <= ST_IDLE;
                end
                default: begin
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.READY = ready_q;
    assign bus.BUSY  = busy_q;
    assign bus.DONE  = done_q;
    assign bus.S     = s_q;
`ifdef LOGIC_FLAGS_EN
    assign bus.Z     = z_q;
    assign bus.P     = p_q;
`endif
endmodule

// File: tb/tb_bit_serial_logic_unit.sv
// Bench for bit_serial_logic_unit (WIDTH 8 and 4 instances).
// Z/P checks are compiled in when LOGIC_FLAGS_EN is defined.
module tb_bit_serial_logic_unit;
    import logic_unit_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;
    logic [7:0] s_prev = 8'h00;

    always #5 clk = ~clk;

    bit_serial_logic_unit_if #(.WIDTH(8)) bus8 ();
    bit_serial_logic_unit_if #(.WIDTH(4)) bus4 ();

    bit_serial_logic_unit #(.WIDTH(8)) dut8 (
        .CLK   (clk),
        .RESET (rst),
        .bus   (bus8)
    );

    bit_serial_logic_unit #(.WIDTH(4)) dut4 (
        .CLK   (clk),
        .RESET (rst),
        .bus   (bus4)
    );

    function automatic logic [7:0] ref8(logic_op_t op, logic [7:0] a,
                                        logic [7:0] b);
        case (op)
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            default: return ~(a | b);
        endcase
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] want);
        n_vec++;
        assert (obs === want) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, want);
        end
    endtask

    task automatic chk_flags8(logic [7:0] s);
`ifdef LOGIC_FLAGS_EN
        chk("z8", 32'(bus8.Z), 32'(s == 8'h00));
        chk("p8", 32'(bus8.P), 32'(^s));
`else
        if (s === 8'hxx) $display("unused %h", s);
`endif
    endtask

    // One full operation on the 8-bit unit with cycle-exact checks.
    task automatic do_op(logic_op_t op, logic [7:0] a, logic [7:0] b,
                         bit hold, bit toggle);
        logic [7:0] want;
        want = ref8(op, a, b);
        @(negedge clk);
        chk("ready_idle", 32'(bus8.READY), 32'd1);
        chk("done_idle", 32'(bus8.DONE), 32'd0);
        chk("s_idle", 32'(bus8.S), 32'(s_prev));
        bus8.START = 1'b1;
        bus8.OP    = op;
        bus8.A     = a;
        bus8.B     = b;
        @(negedge clk);
        if (!hold) bus8.START = 1'b0;
        for (int k = 0; k < 8; k++) begin
            chk("busy_shift", 32'(bus8.BUSY), 32'd1);
            chk("ready_shift", 32'(bus8.READY), 32'd0);
            chk("done_shift", 32'(bus8.DONE), 32'd0);
            chk("s_hold", 32'(bus8.S), 32'(s_prev));
            if (toggle) begin
                bus8.A  = 8'($urandom);
                bus8.B  = 8'($urandom);
                bus8.OP = logic_op_t'($urandom_range(3));
            end
            @(negedge clk);
        end
        chk("done_pulse", 32'(bus8.DONE), 32'd1);
        chk("busy_fin", 32'(bus8.BUSY), 32'd0);
        chk("ready_fin", 32'(bus8.READY), 32'd0);
        chk("s_result", 32'(bus8.S), 32'(want));
        chk_flags8(want);
        s_prev = want;
    endtask

    initial begin
        bus8.START = 1'b0;
        bus8.OP    = OP_AND;
        bus8.A     = '0;
        bus8.B     = '0;
        bus4.START = 1'b0;
        bus4.OP    = OP_AND;
        bus4.A     = '0;
        bus4.B     = '0;

        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(bus8.READY), 32'd1);
        chk("rst_busy", 32'(bus8.BUSY), 32'd0);
        chk("rst_done", 32'(bus8.DONE), 32'd0);
        chk("rst_s", 32'(bus8.S), 32'd0);
        chk("rst_s4", 32'(bus4.S), 32'd0);
        chk_flags8(8'h00);
        rst = 1'b0;

        do_op(OP_OR, 8'hFF, 8'h00, 1'b0, 1'b0);
        do_op(OP_OR, 8'b1001_1101, 8'b1001_1111, 1'b0, 1'b0);
        do_op(OP_AND, 8'hA9, 8'hFF, 1'b0, 1'b0);
        do_op(OP_XOR, 8'hFF, 8'hFF, 1'b0, 1'b0);
        do_op(OP_NOR, 8'h00, 8'h00, 1'b0, 1'b0);

        // START held high: back-to-back ops, operands scrambled mid-shift.
        for (int n = 0; n < 3; n++)
            do_op(logic_op_t'($urandom_range(3)), 8'($urandom),
                  8'($urandom), 1'b1, 1'b1);
        bus8.START = 1'b0;

        for (int n = 0; n < 20; n++)
            do_op(logic_op_t'($urandom_range(3)), 8'($urandom),
                  8'($urandom), 1'b0, (n % 3) == 0);

        // Abort during the 4th shift cycle with an asynchronous reset.
        @(negedge clk);
        bus8.START = 1'b1;
        bus8.OP    = OP_AND;
        bus8.A     = 8'hFF;
        bus8.B     = 8'hFF;
        @(negedge clk);
        bus8.START = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_ready", 32'(bus8.READY), 32'd1);
        chk("arst_busy", 32'(bus8.BUSY), 32'd0);
        chk("arst_done", 32'(bus8.DONE), 32'd0);
        chk("arst_s", 32'(bus8.S), 32'd0);
        chk_flags8(8'h00);
        @(negedge clk);
        rst = 1'b0;
        s_prev = 8'h00;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("no_done", 32'(bus8.DONE), 32'd0);
            chk("arst_idle", 32'(bus8.READY), 32'd1);
        end
        do_op(OP_OR, 8'h0F, 8'hF0, 1'b0, 1'b0);

        // WIDTH=4 instance.
        @(negedge clk);
        chk("w4_ready", 32'(bus4.READY), 32'd1);
        bus4.START = 1'b1;
        bus4.OP    = OP_OR;
        bus4.A     = 4'b1010;
        bus4.B     = 4'b0100;
        @(negedge clk);
        bus4.START = 1'b0;
        repeat (3) @(negedge clk);
        chk("w4_done_early", 32'(bus4.DONE), 32'd0);
        chk("w4_s_early", 32'(bus4.S), 32'd0);
        @(negedge clk);
        chk("w4_done", 32'(bus4.DONE), 32'd1);
        chk("w4_s", 32'(bus4.S), 32'b1110);
`ifdef LOGIC_FLAGS_EN
        chk("w4_p", 32'(bus4.P), 32'd1);
        chk("w4_z", 32'(bus4.Z), 32'd0);
`endif
        @(negedge clk);
        chk("w4_done_low", 32'(bus4.DONE), 32'd0);
        chk("w4_ready_back", 32'(bus4.READY), 32'd1);
        chk("w4_s_hold", 32'(bus4.S), 32'b1110);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
